// File: rtl/mimosa_pkg.sv
// Shared definitions for the behaviour scheduling slice.
//   - sched_state_t : scheduler FSM states (IDLE waits for pending work,
//                     BUSY holds a grant open to the update datapath).
//   - CH_*          : fixed channel assignment of the behaviour-update units.
package mimosa_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sched_state_t;

  localparam int CH_MOOD  = 0;
  localparam int CH_WATER = 1;
  localparam int CH_LIGHT = 2;
  localparam int CH_SPARE = 3;

endpackage

// File: rtl/tick_scheduler_rr_arbiter.sv
// Combinational round-robin pick.
//   pending : one bit per channel requesting service
//   ptr     : channel with highest priority this round
//   sel     : first pending channel found searching from ptr upward (mod NUM_CH)
//   valid   : at least one channel is pending
module rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         pending,
  input  logic [$clog2(NUM_CH)-1:0] ptr,
  output logic [$clog2(NUM_CH)-1:0] sel,
  output logic                      valid
);

  localparam int CH_W = $clog2(NUM_CH);

  int idx;

  // Walk the offsets from farthest to nearest so the nearest pending
  // channel (smallest offset from ptr) is the last one written and wins.
  always_comb begin
    sel   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      idx = (int'(ptr) + off) % NUM_CH;
      if (pending[idx[CH_W-1:0]]) begin
        sel   = idx[CH_W-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Shares the prescaler tick between NUM_CH periodic consumers. Each channel
// counts ticks up to its programmable period and then becomes pending; a
// round-robin arbiter hands one pending channel at a time to the shared
// update datapath and holds the grant until done or a timeout.
//   clk, rst   : system clock, synchronous active-high reset
//   tick_in    : prescaler output, rising edge = one tick
//   en         : global enable (freezes counters and new grants when low)
//   cfg_we     : config write strobe for channel cfg_ch, period cfg_period
//                (period 0 disables the channel)
//   done       : consumer finished the granted update
//   grant      : one-hot grant, held while busy
//   busy       : a grant is open
//   overrun    : sticky per channel, channel expired while already pending
//   timeout    : one-cycle pulse when a grant is aborted
module tick_scheduler
  import mimosa_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int PERIOD_W       = 8,
  parameter int DEFAULT_PERIOD = 1,
  parameter int TIMEOUT        = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick_in,
  input  logic                      en,
  input  logic                      cfg_we,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [PERIOD_W-1:0]       cfg_period,
  input  logic                      done,
  output logic [NUM_CH-1:0]         grant,
  output logic                      busy,
  output logic [NUM_CH-1:0]         overrun,
  output logic                      timeout
);

  localparam int CH_W    = $clog2(NUM_CH);
  localparam int TIMER_W = $clog2(TIMEOUT);

  logic                tick_q_reg;
  logic                tick_rise;
  logic [NUM_CH-1:0]   pending_vec;
  logic [NUM_CH-1:0]   overrun_vec;
  logic [NUM_CH-1:0]   take;
  logic [NUM_CH-1:0]   sel_onehot;
  logic [CH_W-1:0]     sel;
  logic                sel_valid;
  sched_state_t        state_reg, state_next;
  logic [NUM_CH-1:0]   grant_reg, grant_next;
  logic [CH_W-1:0]     ptr_reg, ptr_next;
  logic [TIMER_W-1:0]  timer_reg, timer_next;
  logic                timeout_reg, timeout_next;

  // A tick_in held high counts once.
  assign tick_rise = tick_in & ~tick_q_reg;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .pending (pending_vec),
    .ptr     (ptr_reg),
    .sel     (sel),
    .valid   (sel_valid)
  );

  assign sel_onehot = NUM_CH'(1) << sel;

  // Per-channel period register, tick counter, pending and overrun flags.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [PERIOD_W-1:0] period_reg;
    logic [PERIOD_W-1:0] cnt_reg;
    logic                pend_reg;
    logic                ovr_reg;
    logic                cfg_hit;
    logic                counting;
    logic                expire;

    assign cfg_hit  = cfg_we && (cfg_ch == CH_W'(gi));
    assign counting = tick_rise && en && (period_reg != '0);
    assign expire   = counting && (cnt_reg == period_reg - PERIOD_W'(1));

    always_ff @(posedge clk) begin
      if (rst) begin
        period_reg <= PERIOD_W'(DEFAULT_PERIOD);
        cnt_reg    <= '0;
        pend_reg   <= 1'b0;
        ovr_reg    <= 1'b0;
      end else if (cfg_hit) begin
        // Reconfiguration restarts the channel from a clean state; an
        // open grant on this channel is left alone.
        period_reg <= cfg_period;
        cnt_reg    <= '0;
        pend_reg   <= 1'b0;
        ovr_reg    <= 1'b0;
      end else begin
        if (counting) begin
          cnt_reg <= expire ? '0 : cnt_reg + PERIOD_W'(1);
        end
        // A fresh expiry beats a same-cycle grant so no request is lost.
        if (expire) begin
          pend_reg <= 1'b1;
        end else if (take[gi]) begin
          pend_reg <= 1'b0;
        end
        if (expire && pend_reg && !take[gi]) begin
          ovr_reg <= 1'b1;
        end
      end
    end

    assign pending_vec[gi] = pend_reg;
    assign overrun_vec[gi] = ovr_reg;
  end

  // Grant FSM next-state logic.
  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    ptr_next     = ptr_reg;
    timer_next   = timer_reg;
    timeout_next = 1'b0;
    take         = '0;
    case (state_reg)
      IDLE: begin
        if (en && sel_valid) begin
          grant_next = sel_onehot;
          take       = sel_onehot;
          ptr_next   = (sel == CH_W'(NUM_CH - 1)) ? '0 : sel + CH_W'(1);
          timer_next = '0;
          state_next = BUSY;
        end
      end
      BUSY: begin
        timer_next = timer_reg + TIMER_W'(1);
        if (done) begin
          grant_next = '0;
          state_next = IDLE;
        end else if (timer_reg == TIMER_W'(TIMEOUT - 1)) begin
          grant_next   = '0;
          timeout_next = 1'b1;
          state_next   = IDLE;
        end
      end
      default: begin
        grant_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q_reg  <= 1'b0;
      state_reg   <= IDLE;
      grant_reg   <= '0;
      ptr_reg     <= '0;
      timer_reg   <= '0;
      timeout_reg <= 1'b0;
    end else begin
      tick_q_reg  <= tick_in;
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      ptr_reg     <= ptr_next;
      timer_reg   <= timer_next;
      timeout_reg <= timeout_next;
    end
  end

  assign grant   = grant_reg;
  assign busy    = (state_reg == BUSY);
  assign overrun = overrun_vec;
  assign timeout = timeout_reg;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: a vector table for round-robin order,
// then hand-written sequences for period, overrun, timeout, held tick,
// enable and reset corner cases.
module tb_tick_scheduler;
  import mimosa_pkg::*;

  localparam int NUM_CH   = 4;
  localparam int PERIOD_W = 8;
  localparam int TIMEOUT  = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                tick_in;
  logic                en;
  logic                cfg_we;
  logic [1:0]          cfg_ch;
  logic [PERIOD_W-1:0] cfg_period;
  logic                done;
  logic [NUM_CH-1:0]   grant;
  logic                busy;
  logic [NUM_CH-1:0]   overrun;
  logic                timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tick_scheduler #(
    .NUM_CH         (NUM_CH),
    .PERIOD_W       (PERIOD_W),
    .DEFAULT_PERIOD (1),
    .TIMEOUT        (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_in    (tick_in),
    .en         (en),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .done       (done),
    .grant      (grant),
    .busy       (busy),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  typedef struct packed {
    logic       tick;
    logic       dn;
    logic [3:0] grant;
    logic       busy;
  } vec_t;

  vec_t tbl [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; tick_in = 1'b0; en = 1'b1; cfg_we = 1'b0;
    cfg_ch = '0; cfg_period = '0; done = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic cfg(input int ch, input int p);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_period = PERIOD_W'(p);
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    int n;
    logic prev;
    logic [3:0] exp_g;

    // Round-robin table: inputs applied for one edge, outputs expected after it.
    tbl[0]  = '{1'b1, 1'b0, 4'b0000, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 4'b0001, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 4'b0000, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 4'b0010, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 4'b0000, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 4'b0100, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 4'b0000, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 4'b1000, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 4'b0000, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 4'b0000, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 4'b0001, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 4'b0000, 1'b0};

    // Reset state
    do_reset();
    chk("rst grant", grant, 0);
    chk("rst busy", busy, 0);
    chk("rst overrun", overrun, 0);
    chk("rst timeout", timeout, 0);

    // 1: all periods 1, grants rotate ch0..ch3 then ch0
    for (int i = 0; i < 12; i++) begin
      tick_in = tbl[i].tick;
      done    = tbl[i].dn;
      step();
      $display("vec %0d tick=%0b done=%0b grant=%b busy=%0b overrun=%b", i,
               tbl[i].tick, tbl[i].dn, grant, busy, overrun);
      chk("t1 grant", grant, tbl[i].grant);
      chk("t1 busy", busy, tbl[i].busy);
      chk("t1 overrun", overrun, 0);
      chk("t1 timeout", timeout, 0);
    end
    done = 1'b0;

    // 2: ch1 period 3, others disabled
    do_reset();
    cfg(CH_MOOD, 0); cfg(CH_WATER, 3); cfg(CH_LIGHT, 0); cfg(CH_SPARE, 0);
    n = 0;
    for (int t = 1; t <= 6; t++) begin
      tick_in = 1'b1; step();
      chk("t2 grant on tick edge", grant, 0);
      tick_in = 1'b0; step();
      exp_g = (t % 3 == 0) ? 4'b0010 : 4'b0000;
      $display("tick %0d grant=%b", t, grant);
      chk("t2 grant after pending", grant, exp_g);
      if (grant != 0) begin
        n++;
        done = 1'b1; step(); done = 1'b0;
        chk("t2 release", grant, 0);
      end
    end
    chk("t2 grant count", n, 2);

    // 3: overrun on ch2 while grant held, sticky, cleared by cfg
    do_reset();
    cfg(CH_MOOD, 0); cfg(CH_WATER, 0); cfg(CH_SPARE, 0);
    tick_in = 1'b1; step(); tick_in = 1'b0; step();
    chk("t3 grant ch2", grant, 4'b0100);
    tick_in = 1'b1; step();
    chk("t3 no overrun yet", overrun, 0);
    tick_in = 1'b0; step();
    tick_in = 1'b1; step();
    chk("t3 overrun set", overrun, 4'b0100);
    chk("t3 grant held", grant, 4'b0100);
    tick_in = 1'b0; en = 1'b0; step();
    done = 1'b1; step(); done = 1'b0;
    chk("t3 grant done", grant, 0);
    chk("t3 overrun sticky", overrun, 4'b0100);
    step();
    chk("t3 no grant en=0", grant, 0);
    chk("t3 overrun retained", overrun, 4'b0100);
    cfg(CH_LIGHT, 1);
    chk("t3 cfg clears overrun", overrun, 0);
    en = 1'b1; step(); step();
    chk("t3 cfg clears pending", grant, 0);
    $display("overrun seq grant=%b overrun=%b", grant, overrun);

    // 4: timeout after TIMEOUT cycles, then next pending channel
    do_reset();
    cfg(CH_LIGHT, 0); cfg(CH_SPARE, 0);
    tick_in = 1'b1; step(); tick_in = 1'b0; step();
    chk("t4 grant ch0", grant, 4'b0001);
    for (int k = 1; k < TIMEOUT; k++) begin
      step();
      chk("t4 grant held", grant, 4'b0001);
      chk("t4 no timeout yet", timeout, 0);
    end
    step();
    $display("timeout grant=%b busy=%0b timeout=%0b", grant, busy, timeout);
    chk("t4 grant dropped", grant, 0);
    chk("t4 busy dropped", busy, 0);
    chk("t4 timeout pulse", timeout, 1);
    step();
    chk("t4 next grant ch1", grant, 4'b0010);
    chk("t4 timeout one cycle", timeout, 0);
    for (int k = 1; k < TIMEOUT; k++) step();
    done = 1'b1; step(); done = 1'b0;
    chk("t4 done wins grant", grant, 0);
    chk("t4 done wins timeout", timeout, 0);
    step();
    chk("t4 idle after", grant, 0);
    chk("t4 no late timeout", timeout, 0);

    // 5: tick_in held high counts once
    do_reset();
    cfg(CH_WATER, 0); cfg(CH_LIGHT, 0); cfg(CH_SPARE, 0);
    done = 1'b1; tick_in = 1'b1; n = 0; prev = 1'b0;
    for (int k = 0; k < 13; k++) begin
      if (k == 10) tick_in = 1'b0;
      step();
      if (grant[0] && !prev) n++;
      prev = grant[0];
    end
    done = 1'b0;
    $display("held tick grants=%0d", n);
    chk("t5 one grant", n, 1);
    chk("t5 no overrun", overrun, 0);

    // 6: en=0 mid-grant, then reset mid-grant
    do_reset();
    cfg(CH_WATER, 0); cfg(CH_LIGHT, 0); cfg(CH_SPARE, 0);
    tick_in = 1'b1; step(); tick_in = 1'b0; step();
    chk("t6 grant ch0", grant, 4'b0001);
    en = 1'b0;
    tick_in = 1'b1; step(); tick_in = 1'b0; step();
    chk("t6 grant held en=0", grant, 4'b0001);
    chk("t6 busy en=0", busy, 1);
    done = 1'b1; step(); done = 1'b0;
    chk("t6 grant finishes", grant, 0);
    tick_in = 1'b1; step(); tick_in = 1'b0; step();
    chk("t6 tick ignored en=0", grant, 0);
    en = 1'b1; step(); step();
    chk("t6 no grant after en", grant, 0);
    chk("t6 idle after en", busy, 0);
    tick_in = 1'b1; step(); tick_in = 1'b0; step();
    chk("t6 grant again", grant, 4'b0001);
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6 rst grant", grant, 0);
    chk("t6 rst busy", busy, 0);
    tick_in = 1'b1; step(); tick_in = 1'b0; step();
    chk("t6 post-rst grant ch0", grant, 4'b0001);
    done = 1'b1; step(); done = 1'b0; step();
    chk("t6 default period ch1", grant, 4'b0010);
    $display("reset seq grant=%b", grant);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
